// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register and write-back stage.
//
// The stage accepts one instruction per cycle from MEM through a
// valid/allowin handshake. It captures the synchronous data-RAM read word,
// extracts and extends the load data, and drives the register-file write
// port. rf_wdata also feeds the forwarding taps back to ID/EX.
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   ms_valid       MEM stage holds a valid instruction
//   ms_ready_go    MEM stage has finished this cycle
//   ms_L_type      instruction is a load
//   ms_rd_we       instruction writes rd
//   ms_rd          destination register
//   ms_funct3      load width/sign code
//   ms_result      ALU result, or the load byte address
//   ram_rdata      data-RAM read word, valid in the first WB cycle
//   wb_stall       hold WB this cycle (register-file port busy)
//   flush          kill the WB instruction
//   ws_allowin     WB can accept from MEM this cycle
//   ws_valid       WB holds a valid instruction
//   rf_we          register-file write enable
//   rf_waddr       register-file write address
//   rf_wdata       register-file write data and forwarding value
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ms_valid,
    input  logic              ms_ready_go,
    input  logic              ms_L_type,
    input  logic              ms_rd_we,
    input  logic [REG_AW-1:0] ms_rd,
    input  logic [2:0]        ms_funct3,
    input  logic [DATA_W-1:0] ms_result,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              wb_stall,
    input  logic              flush,
    output logic              ws_allowin,
    output logic              ws_valid,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    // Latched instruction fields.
    logic              l_type;
    logic              rd_we;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] result;

    // The RAM word is only valid in the first WB cycle. If that cycle stalls,
    // the word is parked in rdata_hold so a later write sees the same data.
    logic              first;
    logic              held;
    logic [DATA_W-1:0] rdata_hold;

    logic ws_ready_go;
    logic ms_to_ws_valid;

    assign ws_ready_go    = !wb_stall;
    assign ws_allowin     = !ws_valid || ws_ready_go;
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values that were present before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_valid   <= 1'b0;
            first      <= 1'b0;
            held       <= 1'b0;
            l_type     <= 1'b0;
            rd_we      <= 1'b0;
            rd         <= '0;
            funct3     <= '0;
            result     <= '0;
            rdata_hold <= '0;
        end else if (flush) begin
            // Flush wins over a simultaneous accept.
            ws_valid <= 1'b0;
            first    <= 1'b0;
            held     <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid;
            first    <= ms_to_ws_valid;
            held     <= 1'b0;
            if (ms_to_ws_valid) begin
                l_type <= ms_L_type;
                rd_we  <= ms_rd_we;
                rd     <= ms_rd;
                funct3 <= ms_funct3;
                result <= ms_result;
            end
        end else if (first) begin
            // First WB cycle is stalling: keep the RAM word before it moves.
            rdata_hold <= ram_rdata;
            held       <= 1'b1;
            first      <= 1'b0;
        end
    end

    logic [DATA_W-1:0] load_word;
    logic [1:0]        off;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DATA_W-1:0] load_data;

    assign load_word = held ? rdata_hold : ram_rdata;
    assign off       = result[1:0];
    assign lane_byte = load_word[{off, 3'b000} +: 8];
    assign lane_half = load_word[{off[1], 4'b0000} +: 16];

    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        load_data = load_word;
        case (funct3)
            3'b000:  load_data = {{(DATA_W-8){lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {{(DATA_W-8){1'b0}}, lane_byte};
            3'b001:  load_data = {{(DATA_W-16){lane_half[15]}}, lane_half};
            3'b101:  load_data = {{(DATA_W-16){1'b0}}, lane_half};
            default: load_data = load_word;
        endcase
    end

    assign rf_wdata = l_type ? load_data : result;
    assign rf_waddr = rd;
    // x0 is hard-wired to zero and never written.
    assign rf_we    = ws_valid && ws_ready_go && rd_we && (rd != '0) && !flush;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ms_valid, ms_ready_go, ms_L_type, ms_rd_we;
    logic [4:0]  ms_rd;
    logic [2:0]  ms_funct3;
    logic [31:0] ms_result, ram_rdata;
    logic        wb_stall, flush;
    logic        ws_allowin, ws_valid, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ms_valid(ms_valid), .ms_ready_go(ms_ready_go),
        .ms_L_type(ms_L_type), .ms_rd_we(ms_rd_we), .ms_rd(ms_rd),
        .ms_funct3(ms_funct3), .ms_result(ms_result), .ram_rdata(ram_rdata),
        .wb_stall(wb_stall), .flush(flush),
        .ws_allowin(ws_allowin), .ws_valid(ws_valid),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference model: the instruction sitting in WB and the word it loads.
    typedef struct {
        logic        lt;
        logic        we;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] res;
    } ins_t;

    ins_t        m_ins;
    logic        m_valid;
    logic        m_have_word;
    logic [31:0] m_word;
    logic        obs_we;
    logic [31:0] obs_wdata;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_valid     = 1'b0;
        m_have_word = 1'b0;
        m_word      = '0;
        m_ins       = '{lt: 1'b0, we: 1'b0, rd: 5'd0, f3: 3'd0, res: 32'd0};
    endtask

    // One clock cycle: drive at negedge, compare mid-cycle, update the model at posedge.
    task automatic step(input logic v, input logic lt, input logic we, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [31:0] res,
                        input logic [31:0] rdata, input logic stall, input logic fl);
        logic        e_we;
        logic [31:0] word;
        @(negedge clk);
        ms_valid = v; ms_ready_go = 1'b1; ms_L_type = lt; ms_rd_we = we;
        ms_rd = rd; ms_funct3 = f3; ms_result = res; ram_rdata = rdata;
        wb_stall = stall; flush = fl;
        #1;
        e_we = m_valid && !stall && !fl && m_ins.we && (m_ins.rd != 5'd0);
        word = m_have_word ? m_word : rdata;
        check("ws_valid",   {31'd0, ws_valid},   {31'd0, m_valid});
        check("ws_allowin", {31'd0, ws_allowin}, {31'd0, !m_valid || !stall});
        check("rf_we",      {31'd0, rf_we},      {31'd0, e_we});
        if (m_valid) begin
            check("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_ins.rd});
            check("rf_wdata", rf_wdata,
                  m_ins.lt ? ref_load(m_ins.f3, m_ins.res[1:0], word) : m_ins.res);
        end
        obs_we    = rf_we;
        obs_wdata = rf_wdata;
        @(posedge clk);
        if (fl) begin
            m_valid = 1'b0;
        end else if (!m_valid || !stall) begin
            m_valid     = v;
            m_have_word = 1'b0;
            if (v) m_ins = '{lt: lt, we: we, rd: rd, f3: f3, res: res};
        end else if (!m_have_word) begin
            m_word      = rdata;
            m_have_word = 1'b1;
        end
    endtask

    task automatic idle(input logic [31:0] rdata);
        step(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, rdata, 1'b0, 1'b0);
    endtask

    localparam logic [31:0] W = 32'h80FF_7F01;

    initial begin
        rst_n = 1'b0;
        ms_valid = 0; ms_ready_go = 0; ms_L_type = 0; ms_rd_we = 0;
        ms_rd = '0; ms_funct3 = '0; ms_result = '0; ram_rdata = '0;
        wb_stall = 0; flush = 0;
        model_reset();

        // Reset state.
        @(negedge clk); #1;
        check("rst ws_valid",   {31'd0, ws_valid},   32'd0);
        check("rst ws_allowin", {31'd0, ws_allowin}, 32'd1);
        check("rst rf_we",      {31'd0, rf_we},      32'd0);
        check("rst rf_waddr",   {27'd0, rf_waddr},   32'd0);
        check("rst rf_wdata",   rf_wdata,            32'd0);
        @(negedge clk); rst_n = 1'b1;

        // ALU op to rd=5.
        step(1, 0, 1, 5'd5, 3'd0, 32'h1234_5678, 32'd0, 0, 0);
        idle(32'hFFFF_FFFF);
        check("alu we",    {31'd0, obs_we}, 32'd1);
        check("alu wdata", obs_wdata, 32'h1234_5678);

        // Back-to-back loads; each step presents the RAM word for the previous one.
        step(1, 1, 1, 5'd1, 3'b000, 32'h100 + 3, 32'h0,   0, 0);   // LB  off=3
        step(1, 1, 1, 5'd2, 3'b100, 32'h100 + 3, W,       0, 0);   // LBU off=3
        check("LB",  obs_wdata, 32'hFFFF_FF80);
        step(1, 1, 1, 5'd3, 3'b001, 32'h100 + 2, W,       0, 0);   // LH  off=2
        check("LBU", obs_wdata, 32'h0000_0080);
        step(1, 1, 1, 5'd4, 3'b101, 32'h100 + 0, W,       0, 0);   // LHU off=0
        check("LH",  obs_wdata, 32'hFFFF_80FF);
        step(1, 1, 1, 5'd6, 3'b010, 32'h100 + 1, W,       0, 0);   // LW  off=1
        check("LHU", obs_wdata, 32'h0000_7F01);
        idle(W);
        check("LW",  obs_wdata, 32'h80FF_7F01);

        // LW stalled 3 cycles; RAM output changes after the first WB cycle.
        step(1, 1, 1, 5'd7, 3'b010, 32'h200, 32'h0, 0, 0);
        step(0, 0, 0, 5'd0, 3'd0, 32'd0, W, 1, 0);
        check("stall allowin", {31'd0, ws_allowin}, 32'd0);
        step(0, 0, 0, 5'd0, 3'd0, 32'd0, 32'hDEAD_BEEF, 1, 0);
        step(0, 0, 0, 5'd0, 3'd0, 32'd0, 32'hDEAD_BEEF, 1, 0);
        check("stall we", {31'd0, obs_we}, 32'd0);
        idle(32'hDEAD_BEEF);
        check("stalled LW we",    {31'd0, obs_we}, 32'd1);
        check("stalled LW wdata", obs_wdata, W);

        // Write to x0 never reaches the register file.
        step(1, 0, 1, 5'd0, 3'd0, 32'h55, 32'd0, 0, 0);
        idle(32'd0);
        check("x0 we", {31'd0, obs_we}, 32'd0);

        // Flush in the WB cycle together with a new accept.
        step(1, 0, 1, 5'd9,  3'd0, 32'h99, 32'd0, 0, 0);
        step(1, 0, 1, 5'd10, 3'd0, 32'hAA, 32'd0, 0, 1);
        check("flush we", {31'd0, obs_we}, 32'd0);
        idle(32'd0);
        check("after flush we", {31'd0, obs_we}, 32'd0);

        // Reset pulse during a stalled load.
        step(1, 1, 1, 5'd11, 3'b010, 32'h300, 32'd0, 0, 0);
        step(0, 0, 0, 5'd0, 3'd0, 32'd0, W, 1, 0);
        @(negedge clk);
        rst_n = 1'b0; wb_stall = 1'b1; #1;
        check("mid rst ws_valid", {31'd0, ws_valid}, 32'd0);
        check("mid rst rf_we",    {31'd0, rf_we},    32'd0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        idle(W);
        check("post rst we", {31'd0, obs_we}, 32'd0);
        step(1, 0, 1, 5'd12, 3'd0, 32'hC0FF_EE00, 32'd0, 0, 0);
        idle(32'd0);
        check("post rst write", obs_wdata, 32'hC0FF_EE00);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                 3'($urandom_range(0, 7)), $urandom, $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
